// File: rtl/sc_intr_ctrl.sv
// sc_intr_ctrl: machine-mode trap and interrupt controller for a single-cycle core.
// Holds mstatus/mie/mtvec/mepc/mcause/mip, synchronizes local interrupt lines,
// and decides trap entry, interrupt acknowledgement and fetch redirection.
//
// Ports:
//   clk, clrn                 clock, asynchronous active-low reset
//   irq_in[NUM_IRQ]           asynchronous interrupt request lines
//   instr_valid, pc           current instruction may retire, and its PC
//   exc_req, exc_code         synchronous exception request and cause code
//   mret                      current instruction is MRET
//   csr_en/op/addr/wdata      CSR access (op: 00 read, 01 write, 10 set, 11 clear)
//   csr_rdata, csr_illegal    old CSR value, unimplemented-address flag (combinational)
//   trap_taken, redirect      trap entry this cycle, fetch redirect (combinational)
//   target_pc                 redirect target, 0 when no redirect
//   irq_ack[NUM_IRQ]          one-hot pulse on the channel whose interrupt is taken
module sc_intr_ctrl #(
    parameter int unsigned        NUM_IRQ     = 4,
    parameter int unsigned        SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE    = '0,
    parameter logic [31:0]        RESET_VEC   = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               instr_valid,
    input  logic [31:0]        pc,
    input  logic               exc_req,
    input  logic [4:0]         exc_code,
    input  logic               mret,
    input  logic               csr_en,
    input  logic [1:0]         csr_op,
    input  logic [11:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    output logic               csr_illegal,
    output logic               trap_taken,
    output logic               redirect,
    output logic [31:0]        target_pc,
    output logic [NUM_IRQ-1:0] irq_ack
);

    localparam int unsigned IRQ_BASE = 16;
    localparam int unsigned SEL_W    = 4;

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;

    // Writable mie bits: one per implemented channel starting at bit 16.
    localparam logic [31:0] IRQ_MASK = ((32'h1 << NUM_IRQ) - 32'h1) << IRQ_BASE;

    logic [SYNC_STAGES-1:0] sync_q [NUM_IRQ];
    logic [NUM_IRQ-1:0]     sync_out;
    logic [NUM_IRQ-1:0]     hist_q;
    logic [NUM_IRQ-1:0]     pend_q;
    logic [NUM_IRQ-1:0]     pend_d;
    logic [NUM_IRQ-1:0]     edge_set;
    logic [NUM_IRQ-1:0]     csr_clr;

    logic        mstatus_mie_q;
    logic        mstatus_mpie_q;
    logic [31:0] mie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;

    logic [31:0]      mip;
    logic [31:0]      enabled;
    logic [31:0]      old_val;
    logic [31:0]      new_val;
    logic             legal;
    logic             csr_we;
    logic             int_pend;
    logic             is_int;
    logic             mret_taken;
    logic [SEL_W-1:0] sel;
    logic [4:0]       int_code;
    logic [31:0]      vec_base;

    // Input synchronizers, one shift chain per line.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], irq_in[i]};
            end
        end
    end

    always_comb begin
        sync_out = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Edge channels latch a rising synchronizer output; a new edge beats any clear.
    assign edge_set = sync_out & ~hist_q;

    always_comb begin
        csr_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            csr_clr[i] = csr_we && (csr_addr == ADDR_MIP) && !new_val[IRQ_BASE+i];
        end
    end

    assign pend_d = (edge_set | (pend_q & ~irq_ack & ~csr_clr)) & IRQ_EDGE;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            hist_q <= '0;
            pend_q <= '0;
        end else begin
            hist_q <= sync_out;
            pend_q <= pend_d;
        end
    end

    // Pending view: level channels follow the synchronizer, edge channels the latch.
    always_comb begin
        mip = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            mip[IRQ_BASE+i] = IRQ_EDGE[i] ? pend_q[i] : sync_out[i];
        end
    end

    assign enabled  = mip & mie_q;
    assign int_pend = mstatus_mie_q & (|enabled);

    // Lowest-numbered enabled pending channel wins.
    always_comb begin
        sel = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (enabled[IRQ_BASE+i]) begin
                sel = SEL_W'(i);
            end
        end
    end

    assign int_code   = 5'(IRQ_BASE) + 5'(sel);
    assign trap_taken = instr_valid & (exc_req | int_pend);
    assign is_int     = trap_taken & ~exc_req;
    assign mret_taken = instr_valid & mret & ~trap_taken;
    assign redirect   = trap_taken | mret_taken;
    assign irq_ack    = is_int ? (NUM_IRQ'(1) << sel) : '0;
    assign vec_base   = {mtvec_q[31:2], 2'b00};

    always_comb begin
        target_pc = '0;
        if (trap_taken) begin
            target_pc = vec_base;
            if (is_int && (mtvec_q[1:0] == 2'b01)) begin
                target_pc = vec_base + {25'b0, int_code, 2'b00};
            end
        end else if (mret_taken) begin
            target_pc = mepc_q;
        end
    end

    // CSR read decode; unimplemented addresses read 0.
    always_comb begin
        legal   = 1'b1;
        old_val = '0;
        case (csr_addr)
            ADDR_MSTATUS: old_val = {24'b0, mstatus_mpie_q, 3'b0, mstatus_mie_q, 3'b0};
            ADDR_MIE:     old_val = mie_q;
            ADDR_MTVEC:   old_val = mtvec_q;
            ADDR_MEPC:    old_val = mepc_q;
            ADDR_MCAUSE:  old_val = mcause_q;
            ADDR_MIP:     old_val = mip;
            default:      legal   = 1'b0;
        endcase
    end

    always_comb begin
        case (csr_op)
            2'b01:   new_val = csr_wdata;
            2'b10:   new_val = old_val | csr_wdata;
            2'b11:   new_val = old_val & ~csr_wdata;
            default: new_val = old_val;
        endcase
    end

    assign csr_rdata   = old_val;
    assign csr_illegal = csr_en & ~legal;
    // A trap in the same cycle cancels the instruction's CSR side effect.
    assign csr_we      = csr_en & legal & (csr_op != 2'b00) & ~trap_taken;

    // Architectural CSR state; trap entry takes precedence over CSR writes and mret.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= RESET_VEC;
            mepc_q         <= '0;
            mcause_q       <= '0;
        end else if (trap_taken) begin
            mepc_q         <= pc & ~32'h3;
            mstatus_mpie_q <= mstatus_mie_q;
            mstatus_mie_q  <= 1'b0;
            mcause_q       <= is_int ? {1'b1, 26'b0, int_code} : {27'b0, exc_code};
        end else begin
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie_q  <= new_val[3];
                        mstatus_mpie_q <= new_val[7];
                    end
                    ADDR_MIE:    mie_q    <= new_val & IRQ_MASK;
                    // Reserved modes 2/3 collapse to direct mode.
                    ADDR_MTVEC:  mtvec_q  <= {new_val[31:2], new_val[1] ? 2'b00 : new_val[1:0]};
                    ADDR_MEPC:   mepc_q   <= new_val & ~32'h3;
                    ADDR_MCAUSE: mcause_q <= new_val;
                    default: ;
                endcase
            end
            if (mret_taken) begin
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sc_intr_ctrl.sv
// tb_sc_intr_ctrl: directed bench for sc_intr_ctrl. Two instances share all
// inputs: dut_l has every channel level-sensitive, dut_e has channel 0 edge
// latched and a non-zero mtvec reset value.
module tb_sc_intr_ctrl;

    logic        clk;
    logic        clrn;
    logic [3:0]  irq_in;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        mret;
    logic        csr_en;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;

    logic [31:0] l_rdata, e_rdata;
    logic        l_illegal, e_illegal;
    logic        l_trap, e_trap;
    logic        l_redir, e_redir;
    logic [31:0] l_target, e_target;
    logic [3:0]  l_ack, e_ack;

    int n_pass = 0;
    int n_fail = 0;
    int n_tot  = 0;

    sc_intr_ctrl #(
        .NUM_IRQ(4), .SYNC_STAGES(2), .IRQ_EDGE(4'b0000), .RESET_VEC(32'h0000_0000)
    ) dut_l (
        .clk(clk), .clrn(clrn), .irq_in(irq_in), .instr_valid(instr_valid), .pc(pc),
        .exc_req(exc_req), .exc_code(exc_code), .mret(mret), .csr_en(csr_en),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(l_rdata), .csr_illegal(l_illegal), .trap_taken(l_trap),
        .redirect(l_redir), .target_pc(l_target), .irq_ack(l_ack)
    );

    sc_intr_ctrl #(
        .NUM_IRQ(4), .SYNC_STAGES(2), .IRQ_EDGE(4'b0001), .RESET_VEC(32'h0000_1000)
    ) dut_e (
        .clk(clk), .clrn(clrn), .irq_in(irq_in), .instr_valid(instr_valid), .pc(pc),
        .exc_req(exc_req), .exc_code(exc_code), .mret(mret), .csr_en(csr_en),
        .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
        .csr_rdata(e_rdata), .csr_illegal(e_illegal), .trap_taken(e_trap),
        .redirect(e_redir), .target_pc(e_target), .irq_ack(e_ack)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Read-only CSR access; op 00 has no side effect, so no clock is needed.
    task automatic rd(input string tag, input bit use_e, input logic [11:0] a,
                      input logic [31:0] exp);
        csr_en   = 1'b1;
        csr_op   = 2'b00;
        csr_addr = a;
        #1;
        chk(tag, use_e ? e_rdata : l_rdata, exp);
        csr_en   = 1'b0;
        csr_addr = '0;
    endtask

    task automatic csr_w(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        csr_en    = 1'b1;
        csr_op    = op;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_en    = 1'b0;
        csr_op    = 2'b00;
        csr_addr  = '0;
        csr_wdata = '0;
    endtask

    task automatic idle();
        irq_in      = '0;
        instr_valid = 1'b0;
        pc          = '0;
        exc_req     = 1'b0;
        exc_code    = '0;
        mret        = 1'b0;
        csr_en      = 1'b0;
        csr_op      = 2'b00;
        csr_addr    = '0;
        csr_wdata   = '0;
    endtask

    task automatic rst();
        idle();
        clrn = 1'b0;
        tick();
        clrn = 1'b1;
    endtask

    initial begin
        idle();
        clrn = 1'b0;
        tick();

        // Reset state
        rd("rst_mtvec_l", 1'b0, 12'h305, 32'h0000_0000);
        rd("rst_mtvec_e", 1'b1, 12'h305, 32'h0000_1000);
        rd("rst_mstatus", 1'b0, 12'h300, 32'h0);
        rd("rst_mcause", 1'b0, 12'h342, 32'h0);
        chk("rst_trap", 32'(l_trap), 32'h0);
        chk("rst_redirect", 32'(l_redir), 32'h0);
        chk("rst_target", l_target, 32'h0);
        chk("rst_ack", 32'(l_ack), 32'h0);
        exc_req = 1'b1; instr_valid = 1'b1;
        #1;
        chk("rst_exc_trap", 32'(e_trap), 32'h1);
        chk("rst_exc_target", e_target, 32'h0000_1000);
        idle();
        clrn = 1'b1;
        tick();

        // Level interrupt, vectored mode
        csr_w(2'b01, 12'h305, 32'h0000_0201);
        csr_w(2'b01, 12'h304, 32'hFFF3_FFFF);
        csr_w(2'b10, 12'h300, 32'h0000_0008);
        rd("mtvec_rb", 1'b0, 12'h305, 32'h0000_0201);
        rd("mie_mask", 1'b0, 12'h304, 32'h0003_0000);
        rd("mstatus_set", 1'b0, 12'h300, 32'h0000_0008);
        irq_in = 4'b0011; instr_valid = 1'b1; pc = 32'h100;
        #1;
        chk("lvl_c0_trap", 32'(l_trap), 32'h0);
        tick();
        chk("lvl_c1_trap", 32'(l_trap), 32'h0);
        tick();
        chk("lvl_c2_trap", 32'(l_trap), 32'h1);
        chk("lvl_c2_ack", 32'(l_ack), 32'h1);
        chk("lvl_c2_redir", 32'(l_redir), 32'h1);
        chk("lvl_c2_target", l_target, 32'h0000_0240);
        tick();
        instr_valid = 1'b0;
        rd("lvl_mcause", 1'b0, 12'h342, 32'h8000_0010);
        rd("lvl_mepc", 1'b0, 12'h341, 32'h0000_0100);
        rd("lvl_mstatus", 1'b0, 12'h300, 32'h0000_0080);
        rd("lvl_mip", 1'b0, 12'h344, 32'h0003_0000);
        csr_w(2'b11, 12'h344, 32'h0003_0000);
        rd("lvl_mip_noclr", 1'b0, 12'h344, 32'h0003_0000);
        irq_in = 4'b0000;

        // mret
        csr_w(2'b01, 12'h341, 32'h0000_0104);
        mret = 1'b1; instr_valid = 1'b1;
        #1;
        chk("mret_redir", 32'(l_redir), 32'h1);
        chk("mret_target", l_target, 32'h0000_0104);
        chk("mret_trap", 32'(l_trap), 32'h0);
        tick();
        mret = 1'b0; instr_valid = 1'b0;
        rd("mret_mstatus", 1'b0, 12'h300, 32'h0000_0088);
        rd("mret_mip", 1'b0, 12'h344, 32'h0);

        // Exception beats a pending enabled interrupt
        irq_in = 4'b0001;
        tick();
        tick();
        exc_req = 1'b1; exc_code = 5'd11; instr_valid = 1'b1; pc = 32'h200;
        #1;
        chk("exc_trap", 32'(l_trap), 32'h1);
        chk("exc_ack", 32'(l_ack), 32'h0);
        chk("exc_target", l_target, 32'h0000_0200);
        tick();
        exc_req = 1'b0; instr_valid = 1'b0;
        rd("exc_mcause", 1'b0, 12'h342, 32'h0000_000B);
        rd("exc_mip", 1'b0, 12'h344, 32'h0001_0000);
        rd("exc_mepc", 1'b0, 12'h341, 32'h0000_0200);
        rd("exc_mstatus", 1'b0, 12'h300, 32'h0000_0080);
        irq_in = 4'b0000;

        // Trap discards same-cycle CSR write; illegal address; mepc/mtvec masking
        exc_req = 1'b1; exc_code = 5'd2; instr_valid = 1'b1; pc = 32'h400;
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h341; csr_wdata = 32'hFFFF_FFFF;
        #1;
        chk("trapw_trap", 32'(l_trap), 32'h1);
        chk("legal_addr", 32'(l_illegal), 32'h0);
        tick();
        idle();
        rd("trapw_mepc", 1'b0, 12'h341, 32'h0000_0400);
        csr_w(2'b01, 12'h341, 32'hFFFF_FFFF);
        rd("mepc_align", 1'b0, 12'h341, 32'hFFFF_FFFC);
        csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h1;
        #1;
        chk("illegal_flag", 32'(l_illegal), 32'h1);
        chk("illegal_rdata", l_rdata, 32'h0);
        tick();
        csr_en = 1'b1; csr_op = 2'b00; csr_addr = 12'h341; csr_wdata = 32'h0;
        tick();
        idle();
        rd("op00_nomod", 1'b0, 12'h341, 32'hFFFF_FFFC);
        csr_w(2'b01, 12'h305, 32'h0000_0302);
        rd("mtvec_mode2", 1'b0, 12'h305, 32'h0000_0300);

        // Edge channel 0: pulse latched while MIE=0, taken after csrrs
        rst();
        csr_w(2'b01, 12'h304, 32'h0001_0000);
        instr_valid = 1'b1; pc = 32'h300; irq_in = 4'b0001;
        #1;
        chk("edge_c0_trap", 32'(e_trap), 32'h0);
        tick();
        irq_in = 4'b0000;
        tick();
        rd("edge_mip_early", 1'b1, 12'h344, 32'h0);
        tick();
        rd("edge_mip_set", 1'b1, 12'h344, 32'h0001_0000);
        chk("edge_mie0_trap", 32'(e_trap), 32'h0);
        tick();
        tick();
        rd("edge_mip_held", 1'b1, 12'h344, 32'h0001_0000);
        csr_en = 1'b1; csr_op = 2'b10; csr_addr = 12'h300; csr_wdata = 32'h8;
        #1;
        chk("edge_wr_trap", 32'(e_trap), 32'h0);
        tick();
        csr_en = 1'b0; csr_op = 2'b00; csr_addr = '0; csr_wdata = '0;
        #1;
        chk("edge_trap", 32'(e_trap), 32'h1);
        chk("edge_ack", 32'(e_ack), 32'h1);
        chk("edge_target", e_target, 32'h0000_1000);
        tick();
        instr_valid = 1'b0;
        rd("edge_mip_acked", 1'b1, 12'h344, 32'h0);
        rd("edge_mcause", 1'b1, 12'h342, 32'h8000_0010);
        rd("edge_mstatus", 1'b1, 12'h300, 32'h0000_0080);

        // Reset mid-synchronization: edge lost, held level re-synchronizes
        rst();
        irq_in = 4'b0011;
        tick();
        irq_in = 4'b0010;
        clrn = 1'b0;
        rd("rstsync_in_rst", 1'b1, 12'h344, 32'h0);
        tick();
        clrn = 1'b1;
        tick();
        rd("rstsync_c1", 1'b1, 12'h344, 32'h0);
        tick();
        rd("rstsync_c2", 1'b1, 12'h344, 32'h0002_0000);
        tick();
        tick();
        rd("rstsync_nopend", 1'b1, 12'h344, 32'h0002_0000);
        csr_w(2'b01, 12'h304, 32'h0001_0000);
        csr_w(2'b10, 12'h300, 32'h0000_0008);
        instr_valid = 1'b1;
        #1;
        chk("rstsync_notrap0", 32'(e_trap), 32'h0);
        tick();
        chk("rstsync_notrap1", 32'(e_trap), 32'h0);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/sc_intr_ctrl.md
SC_INTR_CTRL -- requirements
Module: sc_intr_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 4, meaning the number of local interrupt channels (1..16).
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops per irq_in line (>=2).
REQ-003 The block SHALL have parameter IRQ_EDGE, default all-zero, meaning a per-channel mode bitmask (1=rising-edge latched, 0=level).
REQ-004 The block SHALL have parameter RESET_VEC, default 32'h0000_0000, meaning the reset value of mtvec.
REQ-005 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-006 Port clrn, input, 1: reset, asynchronous and active-low.
REQ-007 Port irq_in, input, NUM_IRQ: asynchronous interrupt request lines.
REQ-008 Port instr_valid, input, 1: the current instruction may retire this cycle.
REQ-009 Port pc, input, 32: PC of the current instruction.
REQ-010 Port exc_req, input, 1: synchronous exception from the decoder (ecall, illegal, overflow).
REQ-011 Port exc_code, input, 5: exception cause code.
REQ-012 Port mret, input, 1: the current instruction is MRET.
REQ-013 Port csr_en, input, 1: CSR access.
REQ-014 Port csr_op, input, 2: 00 read-only, 01 write, 10 set bits, 11 clear bits.
REQ-015 Port csr_addr, input, 12: CSR address.
REQ-016 Port csr_wdata, input, 32: CSR operand.
REQ-017 Port csr_rdata, output, 32: old CSR value (combinational).
REQ-018 Port csr_illegal, output, 1: csr_en with unimplemented address.
REQ-019 Port trap_taken, output, 1: trap is entered this cycle.
REQ-020 Port redirect, output, 1: trap_taken or mret taken; fetch from target_pc.
REQ-021 Port target_pc, output, 32: redirect target.
REQ-022 Port irq_ack, output, NUM_IRQ: one-cycle pulse on the channel whose interrupt is taken.

Function
REQ-023 The block SHALL implement mstatus 0x300 (MIE bit 3, MPIE bit 7; other bits read 0), mie 0x304, mtvec 0x305 (bits[1:0]=MODE, 0 direct, 1 vectored, 2/3 write as 0), mepc 0x341 (bit[1:0] forced 0), mcause 0x342, and mip 0x344; all other addresses SHALL assert csr_illegal and read 0.
REQ-024 Channel i SHALL map to mip/mie bit 16+i; unused mip/mie bits SHALL read 0.
REQ-025 Each irq_in[i] SHALL pass through SYNC_STAGES flops; a level channel's mip bit SHALL equal the synchronizer output, visible SYNC_STAGES cycles after irq_in rises, and SHALL ignore CSR writes.
REQ-026 An edge channel SHALL set a pending flop one cycle after the synchronizer output first goes high (0->1 transition), i.e. SYNC_STAGES+1 cycles after irq_in rises, and hold it until the channel is acked or cleared by a CSR write/clear of its mip bit.
REQ-027 When an edge set and a clear (ack or CSR) occur in the same cycle, the set SHALL win.
REQ-028 int_pend SHALL equal mstatus.MIE & |(mip & mie); the selected channel SHALL be the lowest index set in (mip & mie).
REQ-029 trap_taken SHALL equal instr_valid & (exc_req | int_pend); when both are set, the exception SHALL win and irq_ack SHALL stay 0.
REQ-030 On a trap, the next edge SHALL load mepc<=pc, mstatus.MPIE<=MIE, and mstatus.MIE<=0.
REQ-031 On an exception trap, mcause SHALL load {27'b0, exc_code}; on an interrupt trap it SHALL load {1'b1, 26'b0, 16+i}.
REQ-032 target_pc on a trap SHALL be {mtvec[31:2],2'b00}; for an interrupt with MODE=1 it SHALL be that base + 4*(16+i) (mod 2^32).
REQ-033 An mret with instr_valid and no trap SHALL assert redirect with target_pc=mepc, and the next edge SHALL load MIE<=MPIE and MPIE<=1.
REQ-034 When trap_taken is asserted, the same-cycle CSR write and mret state effects SHALL be discarded.
REQ-035 A CSR write, set or clear SHALL take effect on the next edge; csr_op 00, or a write to an illegal address, SHALL modify nothing.
REQ-036 When no redirect is active, target_pc SHALL be 0.

Reset
REQ-037 While clrn=0, the block SHALL hold mstatus, mie, mepc, mcause, all synchronizer, edge-history and pending flops at 0, and mtvec at RESET_VEC.
REQ-038 With clrn=0 and therefore MIE=0 and no pending state, trap_taken, redirect and irq_ack SHALL be 0 unless exc_req&instr_valid.
REQ-039 A reset asserted mid-synchronization SHALL discard the in-flight edge; a still-high level line SHALL re-synchronize after release.

Verification
REQ-040 The bench SHALL cover this scenario: MIE=1, mie=0x3_0000, level irq_in=2'b11 held, instr_valid=1, pc=0x100, mtvec=0x201 -> trap at cycle 2, irq_ack=01, mcause=0x8000_0010, mepc=0x100, target_pc=0x240, MIE=0, MPIE=1.
REQ-041 The bench SHALL cover this scenario: edge channel 0, irq_in 1-cycle pulse with MIE=0 -> mip[16]=1 held; set MIE via csrrs 0x300/0x8 -> trap the cycle after the write, then mip[16]=0.
REQ-042 The bench SHALL cover this scenario: exc_req=1, exc_code=11 with an enabled interrupt pending in the same cycle -> mcause=0x0000_000B, irq_ack=0, interrupt still pending.
REQ-043 The bench SHALL cover this scenario: mret with mepc=0x104, MPIE=1 -> redirect=1, target_pc=0x104, MIE=1, MPIE=1 next cycle.
REQ-044 The bench SHALL cover this scenario: csr write 0x341=0xFFFF_FFFF in the trap cycle -> mepc=pc, not 0xFFFF_FFFC; csr_addr=0x7C0 -> csr_illegal=1, csr_rdata=0.
REQ-045 The bench SHALL cover this scenario: clrn pulsed low one cycle after an edge pulse -> no pending and no trap after release.
